// File: rtl/z80_wait_state_controller.sv
// z80_wait_state_controller: generates Z80 /WAIT for the MSX bus.
// Each bus cycle (M1 fetch, memory, I/O, interrupt acknowledge) is stretched
// by a per-type number of wait states, and the cartridge-slot /WAIT is
// wire-ANDed into the output.
module z80_wait_state_controller #(
    parameter int unsigned M1_WAITS   = 1,
    parameter int unsigned MEM_WAITS  = 0,
    parameter int unsigned IO_WAITS   = 1,
    parameter int unsigned INTA_WAITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m1_n,
    input  logic       mreq_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       wait_en,
    input  logic       ext_wait_n,
    output logic       wait_n,
    output logic       busy,
    output logic [1:0] cycle_type
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned TYPE_W = 2;

    localparam logic [TYPE_W-1:0] CT_M1   = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] CT_MEM  = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] CT_IO   = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] CT_INTA = TYPE_W'(3);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                s_m1_n_q;
    logic                s_mreq_n_q;
    logic                s_iorq_n_q;
    logic                s_rd_n_q;
    logic                s_wr_n_q;
    logic                int_wait_n_q;
    logic                busy_q;
    logic [TYPE_W-1:0]   cycle_type_q;

    logic                cls_hit;
    logic [TYPE_W-1:0]   cls_type;
    logic [CNT_W-1:0]    cls_n;

    // Classify the sampled strobes into a bus-cycle type (priority ordered).
    always_comb begin
        cls_hit  = 1'b0;
        cls_type = CT_M1;
        cls_n    = '0;
        if (!s_mreq_n_q && !s_m1_n_q) begin
            cls_hit  = 1'b1;
            cls_type = CT_M1;
            cls_n    = CNT_W'(M1_WAITS);
        end else if (!s_iorq_n_q && !s_m1_n_q) begin
            cls_hit  = 1'b1;
            cls_type = CT_INTA;
            cls_n    = CNT_W'(INTA_WAITS);
        end else if (!s_mreq_n_q && (!s_rd_n_q || !s_wr_n_q)) begin
            cls_hit  = 1'b1;
            cls_type = CT_MEM;
            cls_n    = CNT_W'(MEM_WAITS);
        end else if (!s_iorq_n_q && (!s_rd_n_q || !s_wr_n_q)) begin
            cls_hit  = 1'b1;
            cls_type = CT_IO;
            cls_n    = CNT_W'(IO_WAITS);
        end
    end

    // Strobe sampling plus IDLE/WAIT/HOLD sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            s_m1_n_q     <= 1'b1;
            s_mreq_n_q   <= 1'b1;
            s_iorq_n_q   <= 1'b1;
            s_rd_n_q     <= 1'b1;
            s_wr_n_q     <= 1'b1;
            int_wait_n_q <= 1'b1;
            busy_q       <= 1'b0;
            cycle_type_q <= CT_M1;
        end else begin
            s_m1_n_q   <= m1_n;
            s_mreq_n_q <= mreq_n;
            s_iorq_n_q <= iorq_n;
            s_rd_n_q   <= rd_n;
            s_wr_n_q   <= wr_n;
            case (state_q)
                ST_IDLE: begin
                    if (cls_hit) begin
                        cycle_type_q <= cls_type;
                        if ((cls_n != '0) && wait_en) begin
                            state_q      <= ST_WAIT;
                            cnt_q        <= cls_n;
                            int_wait_n_q <= 1'b0;
                            busy_q       <= 1'b1;
                        end else begin
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_WAIT: begin
                    // Leaving at cnt = 1 keeps the counter from ever wrapping.
                    if ((cnt_q == CNT_W'(1)) || !wait_en) begin
                        state_q      <= ST_HOLD;
                        int_wait_n_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    // Wait for the bus cycle to end so it cannot retrigger.
                    if (s_mreq_n_q && s_iorq_n_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    int_wait_n_q <= 1'b1;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    // Cartridge /WAIT is wire-ANDed with the registered internal wait.
    assign wait_n     = int_wait_n_q & ext_wait_n;
    assign busy       = busy_q;
    assign cycle_type = cycle_type_q;

endmodule

// File: tb/tb_z80_wait_state_controller.sv
// Bench for z80_wait_state_controller: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_z80_wait_state_controller;

    logic       clk;
    logic       rst_n;
    logic       m1_n, mreq_n, iorq_n, rd_n, wr_n;
    logic       wait_en;
    logic       ext_wait_n;
    logic       wait_n;
    logic       busy;
    logic [1:0] cycle_type;

    int n_cmp;
    int n_err;

    z80_wait_state_controller #(
        .M1_WAITS  (1),
        .MEM_WAITS (0),
        .IO_WAITS  (3),
        .INTA_WAITS(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m1_n      (m1_n),
        .mreq_n    (mreq_n),
        .iorq_n    (iorq_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .wait_en   (wait_en),
        .ext_wait_n(ext_wait_n),
        .wait_n    (wait_n),
        .busy      (busy),
        .cycle_type(cycle_type)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: wait clocks remaining, re-arm flag, last type.
    int m_waits [4] = '{1, 0, 3, 2};   // indexed by type: M1, MEM, IO, INTA
    int m_rem;
    bit m_armed;
    int m_type;
    bit ms_m1, ms_mreq, ms_iorq, ms_rd, ms_wr;

    task automatic model_step();
        int  t;
        bit  hit;
        if (!rst_n) begin
            m_rem = 0; m_armed = 1; m_type = 0;
            ms_m1 = 1; ms_mreq = 1; ms_iorq = 1; ms_rd = 1; ms_wr = 1;
        end else begin
            if (m_rem > 0) begin
                if (!wait_en || m_rem == 1) m_rem = 0;
                else m_rem = m_rem - 1;
            end else if (!m_armed) begin
                if (ms_mreq && ms_iorq) m_armed = 1;
            end else begin
                hit = 1; t = 0;
                if (!ms_mreq && !ms_m1) t = 0;
                else if (!ms_iorq && !ms_m1) t = 3;
                else if (!ms_mreq && (!ms_rd || !ms_wr)) t = 1;
                else if (!ms_iorq && (!ms_rd || !ms_wr)) t = 2;
                else hit = 0;
                if (hit) begin
                    m_type  = t;
                    m_armed = 0;
                    m_rem   = wait_en ? m_waits[t] : 0;
                end
            end
            ms_m1 = m1_n; ms_mreq = mreq_n; ms_iorq = iorq_n; ms_rd = rd_n; ms_wr = wr_n;
        end
    endtask

    // One clock: model follows the edge, outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit m1, input bit mq, input bit io,
                         input bit rd, input bit wr, input bit en, input bit ex);
        rst_n = r; m1_n = m1; mreq_n = mq; iorq_n = io;
        rd_n = rd; wr_n = wr; wait_en = en; ext_wait_n = ex;
    endtask

    typedef struct {
        bit       rst, m1, mreq, iorq, rd, wr, en, ext;
        bit       ew, eb;
        bit [1:0] et;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit r, input bit m1, input bit mq, input bit io,
                       input bit rd, input bit wr, input bit en, input bit ex,
                       input bit ew, input bit eb, input bit [1:0] et);
        vec_t v;
        v.rst = r; v.m1 = m1; v.mreq = mq; v.iorq = io; v.rd = rd; v.wr = wr;
        v.en = en; v.ext = ex; v.ew = ew; v.eb = eb; v.et = et;
        vq.push_back(v);
    endtask

    initial begin
        int lows;
        n_cmp = 0;
        n_err = 0;
        drive(0, 1, 1, 1, 1, 1, 1, 1);

        //  rst m1 mq io rd wr en ex | wait busy type
        add(0, 1, 1, 1, 1, 1, 1, 1,   1, 0, 0);   // reset
        add(1, 1, 1, 1, 1, 1, 1, 1,   1, 0, 0);
        add(1, 0, 0, 1, 0, 1, 1, 1,   1, 0, 0);   // M1 fetch, edge k
        add(1, 0, 0, 1, 0, 1, 1, 1,   0, 1, 0);   // k+1: wait
        add(1, 0, 0, 1, 0, 1, 1, 1,   1, 0, 0);   // released after 1
        add(1, 0, 0, 1, 0, 1, 1, 1,   1, 0, 0);
        add(1, 1, 1, 1, 1, 1, 1, 1,   1, 0, 0);
        add(1, 1, 1, 1, 1, 1, 1, 1,   1, 0, 0);
        add(1, 1, 1, 0, 1, 0, 1, 1,   1, 0, 0);   // IO write, edge k
        add(1, 1, 1, 0, 1, 0, 1, 1,   0, 1, 2);
        add(1, 1, 1, 0, 1, 0, 1, 1,   0, 1, 2);
        add(1, 1, 1, 0, 1, 0, 1, 1,   0, 1, 2);
        add(1, 1, 1, 0, 1, 0, 1, 1,   1, 0, 2);
        add(1, 1, 1, 1, 1, 1, 1, 1,   1, 0, 2);
        add(1, 1, 1, 1, 1, 1, 1, 1,   1, 0, 2);
        add(1, 0, 1, 0, 1, 1, 1, 1,   1, 0, 2);   // INTA, edge k
        add(1, 0, 1, 0, 1, 1, 1, 1,   0, 1, 3);
        add(1, 0, 1, 0, 1, 1, 1, 1,   0, 1, 3);
        add(1, 0, 1, 0, 1, 1, 1, 1,   1, 0, 3);
        add(1, 1, 1, 1, 1, 1, 1, 1,   1, 0, 3);
        add(1, 1, 1, 1, 1, 1, 1, 1,   1, 0, 3);
        add(1, 1, 0, 1, 0, 1, 1, 1,   1, 0, 3);   // MEM read, zero waits
        add(1, 1, 0, 1, 0, 1, 1, 1,   1, 0, 1);
        add(1, 1, 0, 1, 0, 1, 1, 1,   1, 0, 1);
        add(1, 1, 1, 1, 1, 1, 1, 1,   1, 0, 1);
        add(1, 1, 1, 1, 1, 1, 1, 1,   1, 0, 1);
        add(1, 1, 0, 1, 1, 1, 1, 1,   1, 0, 1);   // refresh: ignored
        add(1, 1, 0, 1, 1, 1, 1, 1,   1, 0, 1);
        add(1, 1, 0, 1, 1, 1, 1, 1,   1, 0, 1);
        add(1, 1, 1, 1, 1, 1, 1, 0,   0, 0, 1);   // external wait x4
        add(1, 1, 1, 1, 1, 1, 1, 0,   0, 0, 1);
        add(1, 1, 1, 1, 1, 1, 1, 0,   0, 0, 1);
        add(1, 1, 1, 1, 1, 1, 1, 0,   0, 0, 1);
        add(1, 1, 1, 1, 1, 1, 1, 1,   1, 0, 1);
        add(1, 1, 1, 0, 0, 1, 0, 1,   1, 0, 1);   // IO with wait_en=0
        add(1, 1, 1, 0, 0, 1, 0, 1,   1, 0, 2);
        add(1, 1, 1, 0, 0, 1, 0, 1,   1, 0, 2);
        add(1, 1, 1, 1, 1, 1, 1, 1,   1, 0, 2);
        add(1, 1, 1, 1, 1, 1, 1, 1,   1, 0, 2);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].m1, vq[i].mreq, vq[i].iorq, vq[i].rd, vq[i].wr,
                  vq[i].en, vq[i].ext);
            tick();
            chk($sformatf("vec%0d.wait_n", i), int'(wait_n), int'(vq[i].ew));
            chk($sformatf("vec%0d.busy", i), int'(busy), int'(vq[i].eb));
            chk($sformatf("vec%0d.cycle_type", i), int'(cycle_type), int'(vq[i].et));
        end

        // M1 with MREQ held low for 10 clocks: exactly one wait clock.
        lows = 0;
        drive(1, 0, 0, 1, 0, 1, 1, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!wait_n) lows++;
        end
        chk("m1_long.low_clocks", lows, 1);
        chk("m1_long.type", int'(cycle_type), 0);
        drive(1, 1, 1, 1, 1, 1, 1, 1);
        tick(); tick();

        // wait_en dropped mid-WAIT releases at the next edge.
        drive(1, 1, 1, 0, 1, 0, 1, 1);
        tick(); tick();
        chk("en_drop.wait_before", int'(wait_n), 0);
        wait_en = 1'b0;
        tick();
        chk("en_drop.wait_after", int'(wait_n), 1);
        chk("en_drop.busy_after", int'(busy), 0);
        drive(1, 1, 1, 1, 1, 1, 1, 1);
        tick(); tick();

        // Reset on the second clock of a 3-clock IO wait.
        drive(1, 1, 1, 0, 1, 0, 1, 1);
        tick(); tick();
        chk("rst_mid.wait_before", int'(wait_n), 0);
        tick();
        chk("rst_mid.busy_before", int'(busy), 1);
        drive(0, 1, 1, 1, 1, 1, 1, 1);
        tick();
        chk("rst_mid.wait_after", int'(wait_n), 1);
        chk("rst_mid.busy_after", int'(busy), 0);
        chk("rst_mid.type_after", int'(cycle_type), 0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("rst_mid.wait_later", int'(wait_n), 1);

        // Randomized traffic against the model.
        drive(0, 1, 1, 1, 1, 1, 1, 1);
        tick();
        drive(1, 1, 1, 1, 1, 1, 1, 1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                m1_n   = 1'($urandom_range(0, 1));
                mreq_n = 1'($urandom_range(0, 1));
                iorq_n = 1'($urandom_range(0, 1));
                rd_n   = 1'($urandom_range(0, 1));
                wr_n   = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 5) == 0) begin
                m1_n = 1; mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1;
            end
            wait_en    = ($urandom_range(0, 15) != 0);
            ext_wait_n = ($urandom_range(0, 9) != 0);
            rst_n      = ($urandom_range(0, 199) != 0);
            tick();
            chk("rand.wait_n", int'(wait_n), (m_rem == 0) ? int'(ext_wait_n) : 0);
            chk("rand.busy", int'(busy), (m_rem > 0) ? 1 : 0);
            chk("rand.cycle_type", int'(cycle_type), m_type);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
